// File: rtl/cpu_controller_if.sv
// Control bundle between the instruction decoder, the cpu_controller sequencer
// and the datapath control strobes.
interface cpu_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       illegal;

  modport master (
    output s, opcode, op,
    input  w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel, illegal
  );
endinterface

// File: rtl/cpu_controller.sv
// Instruction sequencer: turns a latched {opcode, op} pair into a Moore sequence
// of register-file, pipeline-register and ALU control strobes.
module cpu_controller (
  input logic          clk,
  input logic          reset,
  cpu_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_e;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       illegal;
  } ctrl_t;

  localparam logic [4:0] I_MOV_IMM = 5'b110_10;
  localparam logic [4:0] I_MOV_SH  = 5'b110_00;
  localparam logic [4:0] I_MVN     = 5'b101_11;
  localparam logic [4:0] I_ADD     = 5'b101_00;
  localparam logic [4:0] I_CMP     = 5'b101_01;
  localparam logic [4:0] I_AND     = 5'b101_10;

  state_e     state_q, state_d;
  logic [4:0] instr_q, instr_d;
  ctrl_t      ctrl_q, ctrl_d;

  function automatic ctrl_t ctrl_for(input state_e st, input logic [4:0] ins);
    ctrl_t c;
    c = '0;
    case (st)
      S_WAIT:      c.w = 1'b1;
      S_DECODE:    c.illegal = !(ins inside {I_MOV_IMM, I_MOV_SH, I_MVN, I_ADD, I_CMP, I_AND});
      S_WRITE_IMM: begin c.nsel = 3'b100; c.vsel = 2'b10; c.write = 1'b1; end
      S_GET_A:     begin c.nsel = 3'b100; c.loada = 1'b1; end
      S_GET_B:     begin c.nsel = 3'b001; c.loadb = 1'b1; end
      S_ALU: begin
        c.loads = (ins == I_CMP);
        c.loadc = (ins != I_CMP);
        c.asel  = (ins == I_MOV_SH) || (ins == I_MVN);
      end
      S_WRITE_REG: begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
      default:     c.w = 1'b1;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      S_WAIT: if (bus.s) begin
        state_d = S_DECODE;
        instr_d = {bus.opcode, bus.op};
      end
      S_DECODE: begin
        case (instr_q)
          I_MOV_IMM:            state_d = S_WRITE_IMM;
          I_MOV_SH, I_MVN:      state_d = S_GET_B;
          I_ADD, I_CMP, I_AND:  state_d = S_GET_A;
          default:              state_d = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = (instr_q == I_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
    ctrl_d = ctrl_for(state_d, instr_d);
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      instr_q <= '0;
      ctrl_q  <= ctrl_for(S_WAIT, 5'b0);
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.w    = ctrl_q.w;
  assign bus.nsel = ctrl_q.nsel;
  assign bus.vsel = ctrl_q.vsel;
  assign bus.asel = ctrl_q.asel;
  assign bus.bsel = ctrl_q.bsel;

  // Reset masks strobes immediately so an aborted instruction never writes back.
  assign bus.write   = ctrl_q.write   & ~reset;
  assign bus.loada   = ctrl_q.loada   & ~reset;
  assign bus.loadb   = ctrl_q.loadb   & ~reset;
  assign bus.loadc   = ctrl_q.loadc   & ~reset;
  assign bus.loads   = ctrl_q.loads   & ~reset;
  assign bus.illegal = ctrl_q.illegal & ~reset;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle expected control vectors are queued
// when an instruction starts and compared as the controller steps through it.
module tb_cpu_controller;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cpu_controller_if bus();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {w, nsel[2:0], vsel[1:0], write, loada, loadb, loadc, loads, asel, bsel, illegal}
  logic [13:0] obs_v;
  assign obs_v = {bus.w, bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb,
                  bus.loadc, bus.loads, bus.asel, bus.bsel, bus.illegal};

  localparam logic [13:0] V_WAIT   = {1'b1, 3'b000, 2'b00, 8'b0000_0000};
  localparam logic [13:0] V_DEC    = {1'b0, 3'b000, 2'b00, 8'b0000_0000};
  localparam logic [13:0] V_DECILL = {1'b0, 3'b000, 2'b00, 8'b0000_0001};
  localparam logic [13:0] V_WIMM   = {1'b0, 3'b100, 2'b10, 8'b1000_0000};
  localparam logic [13:0] V_GETA   = {1'b0, 3'b100, 2'b00, 8'b0100_0000};
  localparam logic [13:0] V_GETB   = {1'b0, 3'b001, 2'b00, 8'b0010_0000};
  localparam logic [13:0] V_ALUSH  = {1'b0, 3'b000, 2'b00, 8'b0001_0100};
  localparam logic [13:0] V_ALUADD = {1'b0, 3'b000, 2'b00, 8'b0001_0000};
  localparam logic [13:0] V_ALUCMP = {1'b0, 3'b000, 2'b00, 8'b0000_1000};
  localparam logic [13:0] V_WREG   = {1'b0, 3'b010, 2'b00, 8'b1000_0000};
  localparam logic [13:0] V_NONE   = 14'b0;

  logic [13:0] sb[$];

  task automatic push_seq(input logic [2:0] opc, input logic [1:0] o);
    case ({opc, o})
      5'b110_10: begin
        sb.push_back(V_DEC); sb.push_back(V_WIMM); sb.push_back(V_WAIT);
      end
      5'b110_00, 5'b101_11: begin
        sb.push_back(V_DEC); sb.push_back(V_GETB); sb.push_back(V_ALUSH);
        sb.push_back(V_WREG); sb.push_back(V_WAIT);
      end
      5'b101_00, 5'b101_10: begin
        sb.push_back(V_DEC); sb.push_back(V_GETA); sb.push_back(V_GETB);
        sb.push_back(V_ALUADD); sb.push_back(V_WREG); sb.push_back(V_WAIT);
      end
      5'b101_01: begin
        sb.push_back(V_DEC); sb.push_back(V_GETA); sb.push_back(V_GETB);
        sb.push_back(V_ALUCMP); sb.push_back(V_WAIT);
      end
      default: begin
        sb.push_back(V_DECILL); sb.push_back(V_WAIT);
      end
    endcase
  endtask

  task automatic chk(input string tag);
    logic [13:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs_v);
    end else begin
      exp = sb.pop_front();
      assert (obs_v === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs_v, exp);
      end
    end
  endtask

  // Start one instruction with s high for a single edge, then scramble the
  // decoder inputs so only the latched copy can steer the sequence.
  task automatic run(input logic [2:0] opc, input logic [1:0] o, input string tag);
    @(negedge clk);
    bus.s = 1'b1; bus.opcode = opc; bus.op = o;
    push_seq(opc, o);
    @(negedge clk);
    bus.s = 1'b0; bus.opcode = 3'($urandom); bus.op = 2'($urandom);
    chk(tag);
    while (sb.size() > 0) begin
      @(negedge clk);
      chk(tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus.s = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
    @(negedge clk); @(negedge clk);
    sb.push_back(V_WAIT); chk("reset_state");
    reset = 1'b0;
    @(negedge clk);
    sb.push_back(V_WAIT); chk("post_reset");

    run(3'b110, 2'b10, "mov_imm");
    run(3'b110, 2'b00, "mov_shift");
    run(3'b101, 2'b00, "add");
    run(3'b101, 2'b01, "cmp");
    run(3'b101, 2'b10, "and");
    run(3'b101, 2'b11, "mvn");
    run(3'b111, 2'b00, "illegal_111");
    run(3'b110, 2'b01, "illegal_110_01");

    // Reset during the ALU cycle of an ADD aborts it without write-back.
    @(negedge clk);
    bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b00;
    sb.push_back(V_DEC); sb.push_back(V_GETA); sb.push_back(V_GETB);
    @(negedge clk); bus.s = 1'b0; chk("abort_dec");
    @(negedge clk); chk("abort_geta");
    @(negedge clk); chk("abort_getb");
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(V_NONE);
    #1 chk("abort_alu_masked");
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(V_WAIT); chk("abort_wait");
    @(negedge clk);
    sb.push_back(V_WAIT); chk("abort_stay_wait");
    run(3'b110, 2'b10, "after_abort_mov");

    // Reset and s together in WAIT: reset wins.
    @(negedge clk);
    reset = 1'b1; bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b10;
    sb.push_back(V_WAIT);
    @(negedge clk);
    chk("reset_beats_s");
    reset = 1'b0; bus.s = 1'b0;
    sb.push_back(V_WAIT);
    @(negedge clk);
    chk("reset_beats_s_after");

    // s held high across return to WAIT starts the next instruction at once.
    @(negedge clk);
    bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b10;
    sb.push_back(V_DEC); sb.push_back(V_WIMM); sb.push_back(V_WAIT);
    sb.push_back(V_DECILL); sb.push_back(V_WAIT);
    @(negedge clk); chk("b2b_dec");
    @(negedge clk); chk("b2b_wimm");
    @(negedge clk); bus.opcode = 3'b111; bus.op = 2'b00; chk("b2b_wait");
    @(negedge clk); bus.s = 1'b0; chk("b2b_illegal");
    @(negedge clk); chk("b2b_final_wait");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-sequencing state machine for the 16-bit cpu. It sits between the instruction register/decoder and the datapath, and converts a decoded opcode/op pair into a per-cycle sequence of register-file, pipeline-register and ALU control strobes. Execution starts on `s` and the block reports idle on `w`. It drives only control signals; all data stays in the datapath.

## Interface
Parameters:
- none; widths fixed by the 16-bit ISA.

Ports (name  direction  width  meaning):
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; takes effect at rising edge of `clk`.
- `s`  in  1  start request; sampled only in WAIT.
- `opcode`  in  3  instruction bits [15:13] from decoder.
- `op`  in  2  instruction bits [12:11] from decoder.
- `w`  out  1  1 when in WAIT (idle, ready for `s`).
- `nsel`  out  3  one-hot register select: 100=Rn, 010=Rd, 001=Rm, 000=none.
- `vsel`  out  2  writeback source: 00=C, 01=PC (unused), 10=sximm8, 11=mdata (unused).
- `write`  out  1  register-file write enable.
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  load enables for A, B, C, status.
- `asel`  out  1  1 forces ALU A operand to 0.
- `bsel`  out  1  1 selects sximm5 for ALU B operand (always 0 in this ISA subset).
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported opcode/op.

## Operation
- State register plus a 5-bit latch of {opcode, op}. The latch captures at the edge leaving WAIT. Decoding in later states uses only latched values, so `opcode`/`op` may change after the start edge.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
- WAIT: `w`=1, all other outputs 0. `s`=1 -> DECODE. Otherwise stay in WAIT.
- DECODE: no strobes. Next state:
  - MOV imm (110,10) -> WRITE_IMM.
  - MOV shift (110,00) and MVN (101,11) -> GET_B.
  - ADD (101,00), CMP (101,01) and AND (101,10) -> GET_A.
  - Any other pair -> WAIT with `illegal`=1 for this cycle.
- WRITE_IMM: `nsel`=100, `vsel`=10, `write`=1 -> WAIT.
- GET_A: `nsel`=100, `loada`=1 -> GET_B.
- GET_B: `nsel`=001, `loadb`=1 -> ALU.
- ALU:
  - `loads`=1 for CMP only; `loadc`=1 for all except CMP.
  - `asel`=1 for MOV shift and MVN; 0 otherwise.
  - Next: CMP -> WAIT; others -> WRITE_REG.
- WRITE_REG: `nsel`=010, `vsel`=00, `write`=1 -> WAIT.
- Outputs are Moore (functions of state and latched instruction only). In every state, outputs not listed are 0.
- If `s` is still 1 on return to WAIT, a new instruction starts on the following edge. This is legal.

## Timing
- Reset: state=WAIT and latch=0 at the first edge with `reset`=1.
  - While `reset`=1, `write`, `loada`, `loadb`, `loadc`, `loads` and `illegal` are forced to 0 combinationally, including mid-instruction.
  - After reset: `w`=1 and every other output 0.
- Reset mid-instruction aborts the instruction. Strobes already issued before the reset cycle stand. No write-back occurs in or after the reset cycle.
- Latency, counted as edges from the edge that samples `s`=1 to the edge returning to WAIT (`w` reasserts after that edge):
  - MOV imm: 3.
  - MOV shift, MVN: 5.
  - CMP: 5.
  - ADD, AND: 6.
  - Illegal: 2.
- Register write occurs at the edge ending WRITE_IMM or WRITE_REG. `w` is 0 during that cycle, so write-back is complete before `w` rises.
- `reset` and `s` both 1 in WAIT: reset wins; stay in WAIT.

## Test plan
- Reset then MOV R0,#100 (opcode 110, op 10), `s` held one cycle:
  - DECODE, WRITE_IMM with `nsel`=100, `vsel`=10, `write`=1.
  - `w`=1 exactly 3 edges after start.
  - With datapath attached, R0=100.
- MOV R1,R0,LSR#1 after the test above:
  - States: DECODE, GET_B (`nsel`=001, `loadb`), ALU (`asel`=1, `loadc`), WRITE_REG (`nsel`=010, `write`).
  - R1=50.
- ADD R2,R0,R1: GET_A asserts `loada` with `nsel`=100. `write` pulses exactly once. `w` returns after 6 edges. R2=150, `out`=150.
- CMP R0,R0:
  - `loads`=1 in ALU; `loadc` and `write` never asserted.
  - `w` returns after 5 edges; Z=1 when attached to the datapath.
- Illegal opcode 111: `illegal` high for exactly one cycle (DECODE). No `load*`/`write` assertions. Back in WAIT after 2 edges.
- ADD in progress, `reset`=1 during the ALU cycle:
  - `loadc` forced 0 that cycle.
  - WAIT at the next edge; no `write` ever asserted.
  - `w`=1 afterwards; a subsequent `s` starts cleanly.
